// File: rtl/el2_exu_mul_receiver.sv
// NoC endpoint that reassembles multi-flit multiply packets {rs1, rs2, mul_p}
// and holds each complete packet until the multiplier consumes it.
module el2_exu_mul_receiver #(
   parameter int FLIT_BITS = 32,
   parameter int MULP_BITS = 24
) (
   input  logic                 clk_noc,
   input  logic                 rst_l,
   input  logic                 flit_valid,
   input  logic                 flit_head,
   input  logic                 flit_tail,
   input  logic [FLIT_BITS-1:0] flit_data,
   output logic                 flit_ready,
   input  logic                 noc_sr_flush,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [MULP_BITS-1:0] mul_p,
   output logic [31:0]          rs1_out,
   output logic [31:0]          rs2_out,
   output logic [7:0]           err_cnt
);

   localparam int PACKET_BITS = 64 + MULP_BITS;
   localparam int NFLITS      = (PACKET_BITS + FLIT_BITS - 1) / FLIT_BITS;
   localparam int BUF_BITS    = NFLITS * FLIT_BITS;
   localparam int IDXW        = (NFLITS > 1) ? $clog2(NFLITS + 1) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFLITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FULL} state_t;

   state_t                state_q, state_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic [BUF_BITS-1:0]   buf_q, buf_d;
   logic [31:0]           rs1_q, rs2_q;
   logic [MULP_BITS-1:0]  mulp_q;
   logic [7:0]            err_q;
   logic                  accept, wr_en, load, err_inc;
   logic [IDXW-1:0]       wr_idx;

   assign accept = flit_valid && (state_q != S_FULL);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wr_en   = 1'b0;
      wr_idx  = '0;
      load    = 1'b0;
      err_inc = 1'b0;
      case (state_q)
         S_IDLE, S_COLLECT: begin
            if (noc_sr_flush) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else if (accept) begin
               if (flit_head) begin
                  // A head in COLLECT abandons the partial packet and restarts from it
                  err_inc = (state_q == S_COLLECT);
                  wr_en   = 1'b1;
                  if (NFLITS == 1 && flit_tail) begin
                     state_d = S_FULL;
                     load    = 1'b1;
                     idx_d   = '0;
                  end else begin
                     state_d = S_COLLECT;
                     idx_d   = IDXW'(1);
                  end
               end else if (state_q == S_IDLE) begin
                  err_inc = 1'b1;
               end else if ((idx_q == LAST_IDX) == flit_tail) begin
                  wr_en  = 1'b1;
                  wr_idx = idx_q;
                  if (flit_tail) begin
                     state_d = S_FULL;
                     load    = 1'b1;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + IDXW'(1);
                  end
               end else begin
                  err_inc = 1'b1;
                  state_d = S_IDLE;
                  idx_d   = '0;
               end
            end
         end
         S_FULL: if (out_ready) state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      buf_d = buf_q;
      if (wr_en) buf_d[(NFLITS - 1 - int'(wr_idx)) * FLIT_BITS +: FLIT_BITS] = flit_data;
   end

   always_ff @(posedge clk_noc or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         buf_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         mulp_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         if (load) begin
            rs1_q  <= buf_d[PACKET_BITS-1 -: 32];
            rs2_q  <= buf_d[PACKET_BITS-33 -: 32];
            mulp_q <= buf_d[MULP_BITS-1:0];
         end
         if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
   end

   // The valid field is the MSB of the packed mul packet and is gated by delivery
   assign flit_ready = (state_q != S_FULL);
   assign out_valid  = (state_q == S_FULL);
   assign mul_p      = {mulp_q[MULP_BITS-1] & out_valid, mulp_q[MULP_BITS-2:0]};
   assign rs1_out    = rs1_q;
   assign rs2_out    = rs2_q;
   assign err_cnt    = err_q;

endmodule

// File: tb/tb_el2_exu_mul_receiver.sv
// Scoreboard bench for el2_exu_mul_receiver: directed packets are queued as
// expectations and a negedge monitor checks each delivery.
module tb_el2_exu_mul_receiver;

   logic        clk_noc = 1'b0;
   logic        rst_l = 1'b0;
   logic        flit_valid = 1'b0;
   logic        flit_head = 1'b0;
   logic        flit_tail = 1'b0;
   logic [31:0] flit_data = '0;
   logic        flit_ready;
   logic        noc_sr_flush = 1'b0;
   logic        out_ready = 1'b1;
   logic        out_valid;
   logic [23:0] mul_p;
   logic [31:0] rs1_out, rs2_out;
   logic [7:0]  err_cnt;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [23:0] mulp;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   el2_exu_mul_receiver #(.FLIT_BITS(32), .MULP_BITS(24)) dut (
      .clk_noc(clk_noc), .rst_l(rst_l), .flit_valid(flit_valid), .flit_head(flit_head),
      .flit_tail(flit_tail), .flit_data(flit_data), .flit_ready(flit_ready),
      .noc_sr_flush(noc_sr_flush), .out_ready(out_ready), .out_valid(out_valid),
      .mul_p(mul_p), .rs1_out(rs1_out), .rs2_out(rs2_out), .err_cnt(err_cnt)
   );

   always #5 clk_noc = ~clk_noc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_noc) begin
      if (rst_l && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_delivery: got rs1=0x%08h rs2=0x%08h expected no packet", rs1_out, rs2_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rs1_out", rs1_out, e.rs1);
            chk("rs2_out", rs2_out, e.rs2);
            chk("mul_p", 32'(mul_p), 32'(e.mulp));
         end
      end
   end

   task automatic send_flit(input logic h, input logic t, input logic [31:0] d);
      int waited = 0;
      flit_valid = 1'b1;
      flit_head  = h;
      flit_tail  = t;
      flit_data  = d;
      @(negedge clk_noc);
      while (!flit_ready && waited < 20) begin
         @(negedge clk_noc);
         waited++;
      end
      if (!flit_ready) chk("flit_ready_timeout", 32'(flit_ready), 32'd1);
      @(posedge clk_noc);
      #1;
      flit_valid = 1'b0;
      flit_head  = 1'b0;
      flit_tail  = 1'b0;
   endtask

   task automatic send_pkt(input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] f2,
                           input logic push, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [23:0] em);
      exp_t e;
      e.rs1 = e1; e.rs2 = e2; e.mulp = em;
      if (push) sb.push_back(e);
      send_flit(1'b1, 1'b0, f0);
      send_flit(1'b0, 1'b0, f1);
      send_flit(1'b0, 1'b1, f2);
      chk("latency_out_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic do_reset();
      #2 rst_l = 1'b0;
      #3 rst_l = 1'b1;
      @(posedge clk_noc);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_noc);
      #1;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_rs1", rs1_out, 32'd0);
      chk("rst_mul_p", 32'(mul_p), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      #5 rst_l = 1'b1;
      @(posedge clk_noc);
      #1;
      chk("rst_flit_ready", 32'(flit_ready), 32'd1);

      // basic packet, valid=1
      send_pkt(32'h00123456, 32'h789ABCDE, 32'hF0800005, 1'b1, 32'h12345678, 32'h9ABCDEF0, 24'h800005);
      idle(2);
      chk("hold_rs1_idle", rs1_out, 32'h12345678);
      chk("hold_mulp_idle", 32'(mul_p), 32'h000005);

      // backpressure: outputs stable while held
      out_ready = 1'b0;
      send_pkt(32'h00DEADBE, 32'hEF000000, 32'h01000003, 1'b1, 32'hDEADBEEF, 32'h00000001, 24'h000003);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_noc);
         chk("stall_flit_ready", 32'(flit_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_rs1", rs1_out, 32'hDEADBEEF);
         chk("stall_rs2", rs2_out, 32'h00000001);
      end
      @(posedge clk_noc);
      #1 out_ready = 1'b1;
      @(posedge clk_noc);
      #1;
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_flit_ready", 32'(flit_ready), 32'd1);
      send_pkt(32'hABFFFFFF, 32'hFFA5A5A5, 32'hA5FFFFFF, 1'b1, 32'hFFFFFFFF, 32'hA5A5A5A5, 24'hFFFFFF);
      idle(2);

      // head, head, body, tail
      do_reset();
      send_flit(1'b1, 1'b0, 32'h00111111);
      send_pkt(32'h00123456, 32'h789ABCDE, 32'hF0800005, 1'b1, 32'h12345678, 32'h9ABCDEF0, 24'h800005);
      idle(2);
      chk("double_head_err", 32'(err_cnt), 32'd1);
      // early tail, then missing tail
      send_flit(1'b1, 1'b0, 32'h00123456);
      send_flit(1'b0, 1'b1, 32'h789ABCDE);
      chk("early_tail_err", 32'(err_cnt), 32'd2);
      chk("early_tail_no_valid", 32'(out_valid), 32'd0);
      send_flit(1'b1, 1'b0, 32'h00123456);
      send_flit(1'b0, 1'b0, 32'h789ABCDE);
      send_flit(1'b0, 1'b0, 32'hF0800005);
      chk("missing_tail_err", 32'(err_cnt), 32'd3);
      chk("missing_tail_no_valid", 32'(out_valid), 32'd0);

      // flush mid-packet, including a flit accepted in the flush cycle
      do_reset();
      send_flit(1'b1, 1'b0, 32'h00DEADBE);
      noc_sr_flush = 1'b1;
      send_flit(1'b0, 1'b0, 32'hEF000000);
      noc_sr_flush = 1'b0;
      send_pkt(32'h00123456, 32'h789ABCDE, 32'hF0800005, 1'b1, 32'h12345678, 32'h9ABCDEF0, 24'h800005);
      idle(2);
      chk("flush_err", 32'(err_cnt), 32'd0);
      // flush while FULL is ignored
      out_ready = 1'b0;
      send_pkt(32'h00DEADBE, 32'hEF000000, 32'h01000003, 1'b1, 32'hDEADBEEF, 32'h00000001, 24'h000003);
      noc_sr_flush = 1'b1;
      idle(1);
      noc_sr_flush = 1'b0;
      chk("flush_full_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      idle(2);

      // stray flits saturate the error counter
      for (int i = 0; i < 300; i++) send_flit(1'b0, 1'b0, 32'(i));
      chk("err_saturate", 32'(err_cnt), 32'd255);

      // reset during COLLECT
      send_flit(1'b1, 1'b0, 32'h00123456);
      send_flit(1'b0, 1'b0, 32'h789ABCDE);
      #2 rst_l = 1'b0;
      #1;
      chk("rstc_rs1", rs1_out, 32'd0);
      chk("rstc_rs2", rs2_out, 32'd0);
      chk("rstc_err", 32'(err_cnt), 32'd0);
      #2 rst_l = 1'b1;
      send_flit(1'b0, 1'b1, 32'hF0800005);
      idle(3);
      chk("rstc_no_valid", 32'(out_valid), 32'd0);

      // reset during FULL
      out_ready = 1'b0;
      send_pkt(32'hABFFFFFF, 32'hFFA5A5A5, 32'hA5FFFFFF, 1'b0, 32'h0, 32'h0, 24'h0);
      #2 rst_l = 1'b0;
      #1;
      chk("rstf_out_valid", 32'(out_valid), 32'd0);
      chk("rstf_mul_p", 32'(mul_p), 32'd0);
      chk("rstf_rs1", rs1_out, 32'd0);
      #2 rst_l = 1'b1;
      out_ready = 1'b1;
      idle(4);
      chk("rstf_no_valid", 32'(out_valid), 32'd0);
      chk("rstf_flit_ready", 32'(flit_ready), 32'd1);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
